// File: rtl/vga_pmod_formatter.sv
// VGA pin formatter: dither/truncate RGB, blank outside DE, map onto Digilent 12-bit or TinyVGA 6-bit PMOD pins.
// Latency: PIPE cycles inputs->pins for colour, sync and uio_oe; mode_active/frame_start 1 cycle after the vs edge.
// Backpressure: none; one pixel per clk, the generator is never stalled.
module vga_pmod_formatter #(
    parameter int IN_BITS     = 4,
    parameter int DITHER      = 1,
    parameter int PIPE        = 1,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_sel,
    input  logic               de,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [IN_BITS-1:0] r_in,
    input  logic [IN_BITS-1:0] g_in,
    input  logic [IN_BITS-1:0] b_in,
    output logic [7:0]         uo_out,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic               mode_active,
    output logic               frame_start
);

    // Bits dropped per channel: Digilent keeps 4, TinyVGA keeps 2.
    localparam int D_DIG  = IN_BITS - 4;
    localparam int D_TVGA = IN_BITS - 2;

    typedef struct packed {
        logic [7:0] uo_dat;
        logic [7:0] uio_dat;
        logic [7:0] oe_dat;
    } pins_t;

    pins_t      pipe_q [PIPE];
    pins_t      pix_pins;
    pins_t      idle_pins;
    logic       xp;
    logic       yp;
    logic       de_q;
    logic       vs_q;
    logic       vs_act_edge;
    logic [1:0] bayer_t;
    logic [3:0] r_red;
    logic [3:0] g_red;
    logic [3:0] b_red;

    // Ordered-dither offset: Bayer index scaled so its range spans the dropped LSBs.
    function automatic logic [IN_BITS:0] dither_thr(input logic tvga, input logic [1:0] t);
        int d;
        d = tvga ? D_TVGA : D_DIG;
        if (DITHER == 1 && d > 0) begin
            return (IN_BITS+1)'((32'(t) << d) >> 2);
        end
        return '0;
    endfunction

    // Add the dither offset with saturation, then keep the top 4 or 2 bits.
    function automatic logic [3:0] reduce(input logic [IN_BITS-1:0] c, input logic tvga,
                                          input logic [1:0] t);
        logic [IN_BITS:0]   sum;
        logic [IN_BITS-1:0] sat;
        sum = {1'b0, c} + dither_thr(tvga, t);
        sat = sum[IN_BITS] ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];
        return tvga ? {2'b00, sat[IN_BITS-1 -: 2]} : sat[IN_BITS-1 -: 4];
    endfunction

    // Pin maps; in TinyVGA mode only bits [1:0] of each channel are meaningful.
    function automatic pins_t map_pins(input logic tvga, input logic hs, input logic vs,
                                       input logic [3:0] r, input logic [3:0] g,
                                       input logic [3:0] b);
        pins_t p;
        if (tvga) begin
            p.uo_dat  = {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
            p.uio_dat = 8'h00;
            p.oe_dat  = 8'h00;
        end else begin
            p.uo_dat  = {b, r};
            p.uio_dat = {2'b00, vs, hs, g};
            p.oe_dat  = 8'hFF;
        end
        return p;
    endfunction

    assign vs_act_edge = (vs_in == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);

    // Reduce and map the current pixel using the parity and mode held before this edge.
    always_comb begin
        bayer_t = 2'd0;
        r_red   = 4'h0;
        g_red   = 4'h0;
        b_red   = 4'h0;
        case ({yp, xp})
            2'b00:   bayer_t = 2'd0;
            2'b01:   bayer_t = 2'd2;
            2'b10:   bayer_t = 2'd3;
            default: bayer_t = 2'd1;
        endcase
        if (de) begin
            r_red = reduce(r_in, mode_active, bayer_t);
            g_red = reduce(g_in, mode_active, bayer_t);
            b_red = reduce(b_in, mode_active, bayer_t);
        end
        pix_pins  = map_pins(mode_active, hs_in, vs_in, r_red, g_red, b_red);
        idle_pins = map_pins(mode_sel, ~SYNC_ACTIVE, ~SYNC_ACTIVE, 4'h0, 4'h0, 4'h0);
    end

    // Frame-synchronous mode latch, vs edge pulse and dither parity tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_active <= mode_sel;
            frame_start <= 1'b0;
            xp          <= 1'b0;
            yp          <= 1'b0;
            de_q        <= 1'b0;
            vs_q        <= vs_in;
        end else begin
            frame_start <= vs_act_edge;
            if (vs_act_edge) begin
                mode_active <= mode_sel;
            end
            xp <= de ? ~xp : 1'b0;
            if (vs_in == SYNC_ACTIVE) begin
                yp <= 1'b0;
            end else if (de_q && !de) begin
                yp <= ~yp;
            end
            de_q <= de;
            vs_q <= vs_in;
        end
    end

    // Pin pipeline: stage 0 takes the mapped pixel, later stages delay it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_q[i] <= idle_pins;
            end
        end else begin
            pipe_q[0] <= pix_pins;
            for (int i = 1; i < PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign uo_out  = pipe_q[PIPE-1].uo_dat;
    assign uio_out = pipe_q[PIPE-1].uio_dat;
    assign uio_oe  = pipe_q[PIPE-1].oe_dat;

endmodule

// File: tb/tb_vga_pmod_formatter.sv
// Bench for vga_pmod_formatter: four instances (PIPE=1..4) sharing one stimulus stream.
// Latency: instance g shows inputs g+1 cycles later; instance 1 (PIPE=2) is the main target.
// Backpressure: none in the design; the bench drives one input set per clock.
module tb_vga_pmod_formatter;
    localparam int IB   = 4;
    localparam bit SA   = 1'b0;
    localparam int NP   = 4;
    localparam int MAIN = 1;

    logic          clk = 1'b0;
    logic          rst, mode_sel, de, hs_in, vs_in;
    logic [IB-1:0] r_in, g_in, b_in;
    logic [7:0]    uo_w  [NP];
    logic [7:0]    uio_w [NP];
    logic [7:0]    oe_w  [NP];
    logic          ma_w  [NP];
    logic          fs_w  [NP];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NP; g++) begin : g_dut
        vga_pmod_formatter #(
            .IN_BITS(IB), .DITHER(1), .PIPE(g + 1), .SYNC_ACTIVE(SA)
        ) u_dut (
            .clk(clk), .rst(rst), .mode_sel(mode_sel), .de(de),
            .hs_in(hs_in), .vs_in(vs_in),
            .r_in(r_in), .g_in(g_in), .b_in(b_in),
            .uo_out(uo_w[g]), .uio_out(uio_w[g]), .uio_oe(oe_w[g]),
            .mode_active(ma_w[g]), .frame_start(fs_w[g])
        );
    end

    // Reference model state: line/pixel counters, latched mode, and expected pin stages.
    int          m_mode, x_cnt, y_cnt;
    logic        m_fs, m_de_prev, m_vs_prev;
    logic [23:0] m_pipe [NP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int chan(input int c, input int mode, input int xp, input int yp);
        int t, d, thr, sum;
        if (yp == 0) t = (xp == 0) ? 0 : 2;
        else         t = (xp == 0) ? 3 : 1;
        d   = IB - ((mode != 0) ? 2 : 4);
        thr = (d > 0) ? (t * (1 << d)) / 4 : 0;
        sum = c + thr;
        if (sum > (1 << IB) - 1) sum = (1 << IB) - 1;
        return sum / (1 << d);
    endfunction

    function automatic logic [23:0] ref_pins(input int mode, input int hs, input int vs,
                                             input int r, input int g, input int b);
        int uo, uio, oe;
        if (mode == 0) begin
            uo = b * 16 + r; uio = vs * 32 + hs * 16 + g; oe = 255;
        end else begin
            uo = hs * 128 + (b % 2) * 64 + (g % 2) * 32 + (r % 2) * 16
               + vs * 8 + (b / 2) * 4 + (g / 2) * 2 + r / 2;
            uio = 0; oe = 0;
        end
        return {uo[7:0], uio[7:0], oe[7:0]};
    endfunction

    task automatic model_edge();
        logic [23:0] s0;
        int rr, gg, bb;
        if (rst) begin
            s0 = ref_pins(int'(mode_sel), int'(!SA), int'(!SA), 0, 0, 0);
            for (int i = 0; i < NP; i++) m_pipe[i] = s0;
            m_mode = int'(mode_sel); m_fs = 1'b0; x_cnt = 0; y_cnt = 0;
            m_de_prev = 1'b0; m_vs_prev = vs_in;
        end else begin
            rr = 0; gg = 0; bb = 0;
            if (de) begin
                rr = chan(int'(r_in), m_mode, x_cnt % 2, y_cnt % 2);
                gg = chan(int'(g_in), m_mode, x_cnt % 2, y_cnt % 2);
                bb = chan(int'(b_in), m_mode, x_cnt % 2, y_cnt % 2);
            end
            s0 = ref_pins(m_mode, int'(hs_in), int'(vs_in), rr, gg, bb);
            for (int i = NP - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = s0;
            m_fs = (vs_in == SA) && (m_vs_prev != SA);
            if (m_fs) m_mode = int'(mode_sel);
            if (de) x_cnt++; else x_cnt = 0;
            if (vs_in == SA) y_cnt = 0;
            else if (m_de_prev && !de) y_cnt++;
            m_de_prev = de; m_vs_prev = vs_in;
        end
    endtask

    // Advance one clock: update the model from the inputs the DUT samples, then settle.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic m, input logic d, input logic h,
                         input logic v, input logic [3:0] rc, input logic [3:0] gc,
                         input logic [3:0] bc);
        rst = r; mode_sel = m; de = d; hs_in = h; vs_in = v;
        r_in = rc; g_in = gc; b_in = bc;
    endtask

    task automatic compare_model(input int cyc);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rand_uo p%0d c%0d", p + 1, cyc), 32'(uo_w[p]), 32'(m_pipe[p][23:16]));
            check($sformatf("rand_uio p%0d c%0d", p + 1, cyc), 32'(uio_w[p]), 32'(m_pipe[p][15:8]));
            check($sformatf("rand_oe p%0d c%0d", p + 1, cyc), 32'(oe_w[p]), 32'(m_pipe[p][7:0]));
            check($sformatf("rand_mode p%0d c%0d", p + 1, cyc), 32'(ma_w[p]), 32'(m_mode));
            check($sformatf("rand_fs p%0d c%0d", p + 1, cyc), 32'(fs_w[p]), 32'(m_fs));
        end
    endtask

    typedef struct packed {
        logic       mode, de, hs, vs;
        logic [3:0] r, g, b;
        logic [7:0] uo, uio, oe;
    } vec_t;

    initial begin
        vec_t       vecs [8];
        logic [7:0] cap  [13];
        int         exp_r [12];
        logic [1:0] got_r;
        logic [7:0] hs_pat [NP];
        logic       vs_r;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 4'hC, 8'hCA, 8'h35, 8'hFF};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h5, 4'hC, 8'h00, 8'h20, 8'hFF};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 4'h3, 8'h3F, 8'h10, 8'hFF};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 4'hC, 8'hED, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 8'h7F, 8'h00, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h4, 4'h8, 4'h3, 8'h92, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 8'h00, 8'h30, 8'hFF};

        // Reset with TinyVGA requested: idle pins and mode taken straight from mode_sel.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        repeat (3) tick();
        check("reset_uo", 32'(uo_w[MAIN]), 32'h88);
        check("reset_uio", 32'(uio_w[MAIN]), 32'h00);
        check("reset_oe", 32'(oe_w[MAIN]), 32'h00);
        check("reset_mode", 32'(ma_w[MAIN]), 32'h1);
        check("reset_fs", 32'(fs_w[MAIN]), 32'h0);

        // Single pixels straight after reset (parity 0, so no dither offset).
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].mode, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
            tick();
            drive(1'b0, vecs[i].mode, vecs[i].de, vecs[i].hs, vecs[i].vs,
                  vecs[i].r, vecs[i].g, vecs[i].b);
            tick();
            drive(1'b0, vecs[i].mode, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
            tick();
            check($sformatf("vec%0d_uo", i), 32'(uo_w[MAIN]), 32'(vecs[i].uo));
            check($sformatf("vec%0d_uio", i), 32'(uio_w[MAIN]), 32'(vecs[i].uio));
            check($sformatf("vec%0d_oe", i), 32'(oe_w[MAIN]), 32'(vecs[i].oe));
        end

        // Dither in TinyVGA: two 2-pixel lines of r=5, then two lines of r=15.
        exp_r = '{1, 1, 0, 2, 1, 0, 3, 3, 0, 3, 3, 0};
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        tick();
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 1'b1, (i < 12) && (i % 3 != 2), 1'b1, 1'b1,
                  (i < 6) ? 4'h5 : 4'hF, 4'h0, 4'h0);
            tick();
            cap[i] = uo_w[MAIN];
        end
        for (int j = 0; j < 12; j++) begin
            got_r = {cap[j+1][0], cap[j+1][4]};
            check($sformatf("dither_r px%0d", j), 32'(got_r), 32'(exp_r[j]));
        end

        // Mode request changes mid-frame; pins stay Digilent until the vs activation.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, (i >= 3), (i % 5 != 4), 1'b1, 1'b1,
                  4'($urandom), 4'($urandom), 4'($urandom));
            tick();
            check($sformatf("midframe_mode c%0d", i), 32'(ma_w[MAIN]), 32'h0);
            check($sformatf("midframe_oe c%0d", i), 32'(oe_w[MAIN]), 32'hFF);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        tick();
        check("switch_fs_pulse", 32'(fs_w[MAIN]), 32'h1);
        check("switch_mode", 32'(ma_w[MAIN]), 32'h1);
        check("switch_oe_edge", 32'(oe_w[MAIN]), 32'hFF);
        tick();
        check("switch_fs_single", 32'(fs_w[MAIN]), 32'h0);
        check("switch_oe_old_px", 32'(oe_w[MAIN]), 32'hFF);
        tick();
        check("switch_oe_new_px", 32'(oe_w[MAIN]), 32'h00);

        // mode_sel changing on the vs edge cycle is the value latched.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        repeat (2) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        tick();
        check("simul_mode", 32'(ma_w[MAIN]), 32'h0);
        check("simul_fs", 32'(fs_w[MAIN]), 32'h1);
        mode_sel = 1'b1;
        tick();
        check("simul_hold_mode", 32'(ma_w[MAIN]), 32'h0);
        check("simul_hold_fs", 32'(fs_w[MAIN]), 32'h0);

        // Single-cycle hs pulse through every PIPE depth, in both pin modes.
        for (int m = 0; m < 2; m++) begin
            drive(1'b1, m[0], 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
            tick();
            drive(1'b0, m[0], 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
            repeat (2) tick();
            for (int c = 0; c < 8; c++) begin
                hs_in = (c == 0) ? 1'b0 : 1'b1;
                tick();
                for (int p = 0; p < NP; p++)
                    hs_pat[p][c] = (m == 1) ? uo_w[p][7] : uio_w[p][4];
            end
            for (int p = 0; p < NP; p++)
                check($sformatf("hs_align mode%0d pipe%0d", m, p + 1),
                      32'(hs_pat[p]), 32'(8'hFF & ~(8'h01 << p)));
        end

        // Random traffic, including mid-frame resets, against the reference model.
        vs_r = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 29) == 0) vs_r = ~vs_r;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) mode_sel = ~mode_sel;
            de    = ($urandom_range(0, 3) != 0);
            hs_in = ($urandom_range(0, 7) != 0);
            vs_in = vs_r;
            r_in  = 4'($urandom);
            g_in  = 4'($urandom);
            b_in  = 4'($urandom);
            tick();
            compare_model(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
